// File: rtl/sc_tx_line_buf_if.sv
// sc_tx_line_buf_if: write/print side and UART-TX side signals of the transmit line buffer.
interface sc_tx_line_buf_if #(parameter int AW = 5);
    logic          wr_valid;
    logic [7:0]    wr_data;
    logic          print;
    logic          tx_busy;
    logic          tx_data_rdy;
    logic [7:0]    tx_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          draining;
    logic          overflow;
    modport master (
        output wr_valid, wr_data, print, tx_busy,
        input  tx_data_rdy, tx_data, count, full, empty, draining, overflow
    );
    modport slave (
        input  wr_valid, wr_data, print, tx_busy,
        output tx_data_rdy, tx_data, count, full, empty, draining, overflow
    );
endinterface

// File: rtl/sc_tx_line_buf.sv
// sc_tx_line_buf: buffers cipher output bytes and drains the line to the UART TX on print.
// Define SC_TXBUF_CRLF_EN to append CR LF after every drained line.
module sc_tx_line_buf #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input logic           clk,
    input logic           rst,
    sc_tx_line_buf_if.slave bus
);
`ifdef SC_TXBUF_CRLF_EN
    typedef enum logic [1:0] {FILL, DRAIN, GAP, TERM} state_t;
`else
    typedef enum logic [1:0] {FILL, DRAIN, GAP} state_t;
`endif
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d, rdy_q, rdy_d, we;
    logic [7:0]    data_q, data_d;
    logic          full;
`ifdef SC_TXBUF_CRLF_EN
    logic [1:0]    term_q, term_d;
`endif

    assign full = count_q == FULL_CNT;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        rdy_d    = 1'b0;
        we       = 1'b0;
        // any write outside FILL, or into a full buffer, is lost
        ovf_d    = ovf_q | (bus.wr_valid && (state_q != FILL || full));
`ifdef SC_TXBUF_CRLF_EN
        term_d   = term_q;
`endif
        case (state_q)
            FILL: begin
                if (bus.wr_valid && !full) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                end
                if (bus.print && count_d != '0) state_d = DRAIN;
`ifdef SC_TXBUF_CRLF_EN
                else if (bus.print) state_d = TERM;
`endif
            end
            DRAIN: begin
                if (count_q == '0) begin
`ifdef SC_TXBUF_CRLF_EN
                    state_d = TERM;
`else
                    state_d = FILL;
`endif
                end else if (!bus.tx_busy) begin
                    data_d   = mem[rd_ptr_q];
                    rdy_d    = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                    state_d  = GAP;
                end
            end
`ifdef SC_TXBUF_CRLF_EN
            GAP: begin
                state_d = term_q == 2'd2 ? FILL : term_q == 2'd1 ? TERM : DRAIN;
                term_d  = term_q == 2'd2 ? 2'd0 : term_q;
            end
            TERM: begin
                if (!bus.tx_busy) begin
                    data_d  = term_q == 2'd0 ? 8'h0D : 8'h0A;
                    rdy_d   = 1'b1;
                    term_d  = term_q + 2'd1;
                    state_d = GAP;
                end
            end
`else
            GAP: state_d = DRAIN;
`endif
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr_q] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rdy_q    <= 1'b0;
            data_q   <= 8'h00;
`ifdef SC_TXBUF_CRLF_EN
            term_q   <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            rdy_q    <= rdy_d;
            data_q   <= data_d;
`ifdef SC_TXBUF_CRLF_EN
            term_q   <= term_d;
`endif
        end
    end

    assign bus.tx_data_rdy = rdy_q;
    assign bus.tx_data     = data_q;
    assign bus.count       = count_q;
    assign bus.full        = full;
    assign bus.empty       = count_q == '0;
    assign bus.draining    = state_q != FILL;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_sc_tx_line_buf.sv
// tb_sc_tx_line_buf: random/directed stimulus against a queue-based model of the line buffer.
module tb_sc_tx_line_buf;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
`ifdef SC_TXBUF_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sc_tx_line_buf_if #(.AW(AW)) bus();
    sc_tx_line_buf #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] q[$];
    bit ovf_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_count"}, 32'(bus.count), 32'(q.size()));
        check({tag, "_empty"}, 32'(bus.empty), 32'(q.size() == 0));
        check({tag, "_full"}, 32'(bus.full), 32'(q.size() == DEPTH));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(ovf_m));
        check({tag, "_draining"}, 32'(bus.draining), 0);
    endtask

    task automatic push_model(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else ovf_m = 1'b1;
    endtask

    task automatic write(input logic [7:0] b);
        bus.wr_valid = 1'b1;
        bus.wr_data  = b;
        step();
        bus.wr_valid = 1'b0;
        push_model(b);
        check_idle("write");
    endtask

    // mode 0: busy never; 1: random busy; 2: busy held 10 cycles after each strobe
    task automatic drain(input int mode, input bit same_wr, input logic [7:0] b, input int wr_at);
        logic [7:0] exp[$];
        int total, n, last, hold, expect_at;
        bit pbusy, busy;
        if (same_wr) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = b;
            push_model(b);
        end
        exp = q;
        q = {};
        if (CRLF) begin
            exp.push_back(8'h0D);
            exp.push_back(8'h0A);
        end
        total = exp.size();
        bus.print   = 1'b1;
        bus.tx_busy = 1'b0;
        last = cyc;
        step();
        bus.print    = 1'b0;
        bus.wr_valid = 1'b0;
        n = 0; hold = 0; pbusy = 1'b0; expect_at = -1;
        for (int i = 0; i < 3000; i++) begin
            if (expect_at == cyc) check("busy_release", 32'(bus.tx_data_rdy), 1);
            if (bus.tx_data_rdy) begin
                check("strobe_after_busy", 32'(pbusy), 0);
                n++;
                if (n > total) check("extra_strobe", n, total);
                else check("data", 32'(bus.tx_data), 32'(exp.pop_front()));
                if (mode == 0) check("spacing", cyc - last, 2);
                last = cyc;
                if (mode == 2) hold = 10;
            end
            if (n == total && !bus.draining && i >= 4) break;
            if (wr_at == i) begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = 8'hEE;
                ovf_m = 1'b1;
            end else bus.wr_valid = 1'b0;
            if (mode == 1) busy = $urandom_range(0, 2) == 0;
            else if (mode == 2 && hold > 0) begin
                busy = 1'b1;
                hold--;
            end else busy = 1'b0;
            if (mode == 2 && pbusy && !busy && n < total) expect_at = cyc + 1;
            bus.tx_busy = busy;
            pbusy = busy;
            step();
        end
        bus.wr_valid = 1'b0;
        bus.tx_busy  = 1'b0;
        check("strobe_total", n, total);
        check_idle("drain");
    endtask

    task automatic reset_mid_drain();
        int n;
        for (int i = 0; i < 20; i++) write(8'(8'h80 + i));
        bus.print = 1'b1;
        step();
        bus.print = 1'b0;
        n = 0;
        for (int i = 0; i < 200 && n < 5; i++) begin
            step();
            if (bus.tx_data_rdy) begin
                check("rst_pre_data", 32'(bus.tx_data), 32'(q.pop_front()));
                n++;
            end
        end
        check("rst_pre_strobes", n, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        q = {};
        ovf_m = 1'b0;
        check("rst_rdy", 32'(bus.tx_data_rdy), 0);
        check_idle("rst_mid");
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            n += int'(bus.tx_data_rdy);
        end
        check("rst_no_strobes", n, 0);
        write(8'h5A);
        drain(0, 1'b0, 8'h00, -1);
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.print    = 1'b0;
        bus.tx_busy  = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_rdy", 32'(bus.tx_data_rdy), 0);
        check("reset_data", 32'(bus.tx_data), 0);
        check_idle("reset");

        write(8'h41); write(8'h42); write(8'h43);
        drain(0, 1'b0, 8'h00, -1);

        write(8'h11); write(8'h22);
        drain(0, 1'b1, 8'h33, -1);

        for (int i = 0; i < 4; i++) write(8'($urandom));
        drain(2, 1'b0, 8'h00, -1);

        drain(0, 1'b0, 8'h00, -1);

        for (int i = 0; i < 33; i++) write(8'(i + 1));
        drain(1, 1'b0, 8'h00, -1);

        reset_mid_drain();

        for (int i = 0; i < 20; i++) write(8'($urandom));
        drain(0, 1'b0, 8'h00, -1);
        for (int i = 0; i < 20; i++) write(8'($urandom));
        drain(0, 1'b0, 8'h00, 6);

        for (int r = 0; r < 10; r++) begin
            int len = $urandom_range(0, 35);
            for (int i = 0; i < len; i++) write(8'($urandom));
            drain(int'($urandom_range(0, 2)), 1'($urandom), 8'($urandom),
                  $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 15)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
